// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_buf.sv
// Fetch buffer: DEPTH-entry synchronous FIFO of fetch packets; flush wins over push.
module fetch_buf
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_pkt_t       push_pkt,
    output logic [CNT_W-1:0] count,
    output fetch_pkt_t       head
);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    fetch_pkt_t       mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: the storage array is not reset; count alone decides which entries are visible.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_pkt;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

    // The credit logic upstream must never push into a full buffer.
    always_ff @(posedge clk) begin
        if (!reset && !flush)
            assert (!(push && !pop && count == CNT_W'(DEPTH)));
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives the instruction SRAM,
// buffers {pc,inst} packets and hands them to decode; branch redirects flush.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = fetch_unit_pkg::RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_adef
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int FILL_W = CNT_W + 1;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [31:0]       fetch_pc;
    logic [31:0]       issued_pc;
    logic [31:0]       issue_pc;
    logic              inflight;
    logic              halted;
    logic              redirect;
    logic              kill;
    logic              deq;
    logic              credit;
    logic [CNT_W-1:0]  count;
    logic [FILL_W-1:0] fill;
    fetch_pkt_t        head;
    fetch_pkt_t        rsp_pkt;

    assign inst_sram_we    = 1'b0;
    assign inst_sram_wdata = '0;

    assign redirect = br_valid && (state == RUN);
    assign kill     = redirect;
    assign id_valid = (count != '0) && !redirect;
    assign deq      = id_valid && id_ready;

    // Occupancy once this cycle settles: buffered + returning - leaving.
    assign fill   = {1'b0, count} + FILL_W'(inflight) - FILL_W'(deq);
    assign credit = fill < FILL_W'(DEPTH);

    always_ff @(posedge clk) begin
        if (reset)
            state <= BOOT;
        else
            state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next   = state;
        inst_sram_en = 1'b0;
        issue_pc     = fetch_pc;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (redirect) begin
                    issue_pc     = br_target;
                    inst_sram_en = 1'b1;
                end else begin
                    inst_sram_en = !halted && credit;
                end
            end
        endcase
        if (reset)
            inst_sram_en = 1'b0;
    end

    assign inst_sram_addr = {issue_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= '0;
            inflight  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            inflight <= inst_sram_en;
            if (inst_sram_en) begin
                issued_pc <= issue_pc;
                fetch_pc  <= inst_sram_addr + 32'd4;
                // A misaligned fetch is the last one until the core redirects.
                halted    <= (issue_pc[1:0] != 2'b00);
            end else if (state == BOOT && br_valid) begin
                fetch_pc <= br_target;
                halted   <= 1'b0;
            end
        end
    end

    assign rsp_pkt = '{pc: issued_pc, inst: inst_sram_rdata, adef: (issued_pc[1:0] != 2'b00)};

    fetch_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (inflight && !kill),
        .pop      (deq),
        .flush    (kill),
        .push_pkt (rsp_pkt),
        .count    (count),
        .head     (head)
    );

    assign id_pc   = head.pc;
    assign id_inst = head.inst;
    assign id_adef = head.adef;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: SRAM model returns addr ^ 0xDEADBEEF one cycle after a request.
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] A0    = 32'h1c00_0000;
    localparam logic [31:0] SALT  = 32'hDEAD_BEEF;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        br_valid  = 1'b0;
    logic [31:0] br_target = '0;
    logic        id_ready  = 1'b0;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adef;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(
        .RESET_PC (A0),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .br_valid        (br_valid),
        .br_target       (br_target),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .id_adef         (id_adef)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (inst_sram_en)
            inst_sram_rdata <= inst_sram_addr ^ SALT;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are checked 1 ns later.
    task automatic step(input logic rst, input logic rdy, input logic br, input logic [31:0] tgt);
        @(negedge clk);
        reset     = rst;
        id_ready  = rdy;
        br_valid  = br;
        br_target = tgt;
        #1;
    endtask

    task automatic expect_issue(input string tag, input logic [31:0] addr);
        check({tag, ".en"}, 32'(inst_sram_en), 32'd1);
        check({tag, ".addr"}, inst_sram_addr, addr);
    endtask

    task automatic expect_no_issue(input string tag);
        check({tag, ".en"}, 32'(inst_sram_en), 32'd0);
    endtask

    task automatic expect_empty(input string tag);
        check({tag, ".valid"}, 32'(id_valid), 32'd0);
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc, input logic adef);
        logic [31:0] word_addr;
        word_addr = {pc[31:2], 2'b00};
        check({tag, ".valid"}, 32'(id_valid), 32'd1);
        check({tag, ".pc"}, id_pc, pc);
        check({tag, ".inst"}, id_inst, word_addr ^ SALT);
        check({tag, ".adef"}, 32'(id_adef), 32'(adef));
    endtask

    initial begin
        // Reset values
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        expect_no_issue("rst");
        check("rst.addr", inst_sram_addr, A0);
        expect_empty("rst");
        check("rst.pc", id_pc, 32'd0);
        check("rst.inst", id_inst, 32'd0);
        check("rst.adef", 32'(id_adef), 32'd0);
        check("rst.we", 32'(inst_sram_we), 32'd0);
        check("rst.wdata", inst_sram_wdata, 32'd0);

        // Boot cycle, then one packet per cycle
        step(1'b0, 1'b1, 1'b0, '0);
        expect_no_issue("boot");
        check("boot.addr", inst_sram_addr, A0);
        expect_empty("boot");
        step(1'b0, 1'b1, 1'b0, '0);
        expect_issue("first", A0);
        step(1'b0, 1'b1, 1'b0, '0);
        expect_issue("second", A0 + 32'd4);
        expect_empty("second");
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 1'b0, '0);
            expect_head("stream", A0 + 32'(4 * k), 1'b0);
            expect_issue("stream", A0 + 32'(4 * (k + 2)));
        end

        // Decode stalls for 10 cycles: buffer fills to DEPTH, then fetch stops
        step(1'b0, 1'b0, 1'b0, '0);
        expect_head("stall0", A0 + 32'd24, 1'b0);
        expect_issue("stall0", A0 + 32'd32);
        step(1'b0, 1'b0, 1'b0, '0);
        expect_head("stall1", A0 + 32'd24, 1'b0);
        expect_issue("stall1", A0 + 32'd36);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b0, '0);
            expect_no_issue("stall_full");
            check("stall_full.pc", id_pc, A0 + 32'd24);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b0, '0);
            expect_head("drain", A0 + 32'(4 * (6 + k)), 1'b0);
        end

        // Reset mid-stream with packets buffered
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        expect_empty("rst_mid");
        expect_no_issue("rst_mid");
        check("rst_mid.addr", inst_sram_addr, A0);
        step(1'b0, 1'b1, 1'b0, '0);
        expect_issue("restart", A0);
        step(1'b0, 1'b1, 1'b0, '0);
        expect_issue("restart2", A0 + 32'd4);
        expect_empty("restart2");

        // Redirect with 2 buffered and 1 in flight
        step(1'b0, 1'b0, 1'b0, '0);
        expect_head("pre_br", A0, 1'b0);
        expect_issue("pre_br", A0 + 32'd8);
        step(1'b0, 1'b1, 1'b1, 32'h1c00_0100);
        expect_empty("br");
        expect_issue("br", 32'h1c00_0100);
        step(1'b0, 1'b1, 1'b0, '0);
        expect_empty("post_br");
        check("post_br.pc", id_pc, 32'd0);
        expect_issue("post_br", 32'h1c00_0104);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, '0);
            expect_head("br_stream", 32'h1c00_0100 + 32'(4 * k), 1'b0);
        end

        // Misaligned redirect: one adef packet, then fetch halts until the next redirect
        step(1'b0, 1'b1, 1'b1, 32'h1c00_0102);
        expect_empty("mis_br");
        expect_issue("mis_br", 32'h1c00_0100);
        step(1'b0, 1'b1, 1'b0, '0);
        expect_empty("mis_wait");
        expect_no_issue("mis_wait");
        step(1'b0, 1'b1, 1'b0, '0);
        expect_head("mis_pkt", 32'h1c00_0102, 1'b1);
        expect_no_issue("mis_pkt");
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, 1'b0, '0);
            expect_empty("halted");
            expect_no_issue("halted");
        end
        step(1'b0, 1'b1, 1'b1, 32'h1c00_0200);
        expect_issue("resume", 32'h1c00_0200);
        step(1'b0, 1'b1, 1'b0, '0);
        expect_issue("resume2", 32'h1c00_0204);
        step(1'b0, 1'b1, 1'b0, '0);
        expect_head("resume_pkt", 32'h1c00_0200, 1'b0);

        // Address wrap at the top of the 32-bit space
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        expect_empty("wrap_br");
        expect_issue("wrap_br", 32'hFFFF_FFF8);
        step(1'b0, 1'b1, 1'b0, '0);
        expect_issue("wrap1", 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, '0);
        expect_head("wrap_a", 32'hFFFF_FFF8, 1'b0);
        expect_issue("wrap2", 32'h0000_0000);
        step(1'b0, 1'b1, 1'b0, '0);
        expect_head("wrap_b", 32'hFFFF_FFFC, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0);
        expect_head("wrap_c", 32'h0000_0000, 1'b0);

        // Redirect during BOOT is latched, not issued
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 32'h1c00_0300);
        expect_no_issue("boot_br");
        expect_empty("boot_br");
        step(1'b0, 1'b1, 1'b0, '0);
        expect_issue("boot_tgt", 32'h1c00_0300);
        step(1'b0, 1'b1, 1'b0, '0);
        expect_issue("boot_tgt2", 32'h1c00_0304);
        step(1'b0, 1'b1, 1'b0, '0);
        expect_head("boot_pkt", 32'h1c00_0300, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
